// File: rtl/defog_recover.sv
// Dark-channel defog recovery: J = A + (I - A) / max(t, t_min), four-stage pipeline
// with frame-latched atmosphere, t_min and mode, plus a per-frame clamp counter.
module defog_recover #(
    parameter int DW        = 8,
    parameter int CH        = 3,
    parameter int RF        = 12,
    parameter int T_MIN_DEF = 26
) (
    input  logic             pixelclk,
    input  logic             reset_n,
    input  logic [CH*DW-1:0] i_rgb,
    input  logic [DW-1:0]    i_transmittance,
    input  logic [CH*DW-1:0] i_atmos,
    input  logic [DW-1:0]    i_t_min,
    input  logic [1:0]       i_mode,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    output logic [CH*DW-1:0] o_defogging,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [23:0]      o_sat_cnt
);
    localparam int RW = DW + RF;
    localparam int PW = DW + RW + 2;
    localparam int CW = $clog2(CH + 1);
    localparam longint unsigned NUM = ((64'd1 << DW) - 64'd1) << RF;
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (RF - 1));
    localparam logic signed [PW-1:0] PMAX = PW'((2 ** DW) - 1);

    function automatic logic [DW-1:0] t_floor(input logic [DW-1:0] t, input logic [DW-1:0] tm);
        logic [DW-1:0] m;
        m = (t > tm) ? t : tm;
        return (m == '0) ? DW'(1) : m;
    endfunction

    // Returns {clamped, pixel}.
    function automatic logic [DW:0] round_clamp(input logic signed [PW-1:0] p,
                                                input logic [DW-1:0] a);
        logic signed [PW-1:0] j;
        j = ((p + HALF) >>> RF) + $signed({{(PW-DW){1'b0}}, a});
        if (j < 0) return {1'b1, {DW{1'b0}}};
        if (j > PMAX) return {1'b1, {DW{1'b1}}};
        return {1'b0, j[DW-1:0]};
    endfunction

    function automatic logic [23:0] sat_add(input logic [23:0] acc, input logic [CW-1:0] n);
        logic [24:0] s;
        s = {1'b0, acc} + 25'(n);
        return s[24] ? 24'hFF_FFFF : s[23:0];
    endfunction

    // Reciprocal ROM, folded into constants at elaboration; entry 0 is never addressed.
    logic [RW-1:0] recip_tab [2**DW];
    for (genvar g = 0; g < 2**DW; g++) begin : g_recip
        localparam longint unsigned DEN = (g == 0) ? 64'd1 : 64'(g);
        assign recip_tab[g] = RW'(NUM / DEN);
    end

    logic [CH*DW-1:0]     atmos_lat;
    logic [DW-1:0]        tmin_lat;
    logic [1:0]           mode_lat;
    logic [CH*DW-1:0]     rgb_p1, rgb_p2, rgb_p3;
    logic [CH*DW-1:0]     atmos_p1, atmos_p2, atmos_p3;
    logic [DW-1:0]        t_p1, t_p2, t_p3, teff_p1;
    logic [1:0]           mode_p1, mode_p2, mode_p3;
    logic [2:0]           sync_p1, sync_p2, sync_p3;
    logic signed [DW:0]   diff_p1 [CH];
    logic signed [DW:0]   diff_p2 [CH];
    logic [RW-1:0]        recip_p2;
    logic signed [PW-1:0] prod_p3 [CH];
    logic [23:0]          sat_acc;

    logic [CH*DW-1:0] out_s4;
    logic [CW-1:0]    nclamp_s4;
    logic             count_s4;

    always_comb begin
        logic [DW:0]      rc;
        logic [CH*DW-1:0] rec_pix;
        rc        = '0;
        rec_pix   = '0;
        nclamp_s4 = '0;
        for (int c = 0; c < CH; c++) begin
            rc = round_clamp(prod_p3[c], atmos_p3[(CH-1-c)*DW +: DW]);
            rec_pix[(CH-1-c)*DW +: DW] = rc[DW-1:0];
            nclamp_s4 = nclamp_s4 + CW'(rc[DW]);
        end
        case (mode_p3)
            2'b01:   out_s4 = rgb_p3;
            2'b10:   out_s4 = {CH{t_p3}};
            default: out_s4 = rec_pix;
        endcase
        if (!sync_p3[0]) out_s4 = '0;
        count_s4 = sync_p3[0] && (mode_p3[1] == mode_p3[0]);
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            atmos_lat   <= '1;
            tmin_lat    <= DW'(T_MIN_DEF);
            mode_lat    <= 2'b00;
            rgb_p1      <= '0;
            rgb_p2      <= '0;
            rgb_p3      <= '0;
            atmos_p1    <= '0;
            atmos_p2    <= '0;
            atmos_p3    <= '0;
            t_p1        <= '0;
            t_p2        <= '0;
            t_p3        <= '0;
            teff_p1     <= '0;
            mode_p1     <= '0;
            mode_p2     <= '0;
            mode_p3     <= '0;
            sync_p1     <= '0;
            sync_p2     <= '0;
            sync_p3     <= '0;
            recip_p2    <= '0;
            for (int c = 0; c < CH; c++) begin
                diff_p1[c] <= '0;
                diff_p2[c] <= '0;
                prod_p3[c] <= '0;
            end
            o_defogging <= '0;
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
            o_de        <= 1'b0;
            o_sat_cnt   <= '0;
            sat_acc     <= '0;
        end else begin
            if (i_vsync && !sync_p1[1]) begin
                atmos_lat <= i_atmos;
                tmin_lat  <= i_t_min;
                mode_lat  <= i_mode;
            end
            // S1: capture pixel, floor t, form I - A
            rgb_p1   <= i_rgb;
            t_p1     <= i_transmittance;
            teff_p1  <= t_floor(i_transmittance, tmin_lat);
            atmos_p1 <= atmos_lat;
            mode_p1  <= mode_lat;
            sync_p1  <= {i_hsync, i_vsync, i_de};
            for (int c = 0; c < CH; c++)
                diff_p1[c] <= $signed({1'b0, i_rgb[(CH-1-c)*DW +: DW]})
                            - $signed({1'b0, atmos_lat[(CH-1-c)*DW +: DW]});
            // S2: reciprocal lookup
            recip_p2 <= recip_tab[teff_p1];
            diff_p2  <= diff_p1;
            rgb_p2   <= rgb_p1;
            t_p2     <= t_p1;
            atmos_p2 <= atmos_p1;
            mode_p2  <= mode_p1;
            sync_p2  <= sync_p1;
            // S3: full-precision product
            for (int c = 0; c < CH; c++)
                prod_p3[c] <= PW'(diff_p2[c]) * PW'($signed({1'b0, recip_p2}));
            rgb_p3   <= rgb_p2;
            t_p3     <= t_p2;
            atmos_p3 <= atmos_p2;
            mode_p3  <= mode_p2;
            sync_p3  <= sync_p2;
            // S4: round, add, clamp, mode select; clamps on the vsync-rise cycle open the new frame
            o_defogging <= out_s4;
            {o_hsync, o_vsync, o_de} <= sync_p3;
            if (sync_p3[1] && !o_vsync) begin
                o_sat_cnt <= sat_acc;
                sat_acc   <= count_s4 ? 24'(nclamp_s4) : 24'd0;
            end else if (count_s4) begin
                sat_acc <= sat_add(sat_acc, nclamp_s4);
            end
        end
    end
endmodule

// File: tb/tb_defog_recover.sv
// Scoreboard bench for defog_recover: directed pixels with hand-computed results,
// checked by a monitor against 4-cycle-delayed expectations.
module tb_defog_recover;
    logic        pixelclk = 1'b0;
    logic        reset_n  = 1'b0;
    logic [23:0] i_rgb = '0, i_atmos = '0;
    logic [7:0]  i_transmittance = '0, i_t_min = '0;
    logic [1:0]  i_mode = '0;
    logic        i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
    logic [23:0] o_defogging;
    logic        o_hsync, o_vsync, o_de;
    logic [23:0] o_sat_cnt;

    defog_recover #(.DW(8), .CH(3), .RF(12), .T_MIN_DEF(26)) dut (
        .pixelclk(pixelclk), .reset_n(reset_n),
        .i_rgb(i_rgb), .i_transmittance(i_transmittance), .i_atmos(i_atmos),
        .i_t_min(i_t_min), .i_mode(i_mode),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .o_defogging(o_defogging), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
        .o_sat_cnt(o_sat_cnt)
    );

    always #5 pixelclk = ~pixelclk;

    typedef struct {
        int          stamp;
        logic [2:0]  sync;
        logic [23:0] pix;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    always @(posedge pixelclk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    task automatic drive(input logic [23:0] rgb, input logic [7:0] t, input logic hs,
                         input logic vs, input logic de, input logic [23:0] expv);
        exp_t e;
        @(posedge pixelclk);
        #1;
        i_rgb = rgb; i_transmittance = t; i_hsync = hs; i_vsync = vs; i_de = de;
        e.stamp = cyc_n + 4;
        e.sync  = {hs, vs, de};
        e.pix   = de ? expv : 24'h0;
        exp_q.push_back(e);
    endtask

    task automatic pix(input logic [23:0] rgb, input logic [7:0] t, input logic [23:0] expv);
        drive(rgb, t, 1'b0, 1'b0, 1'b1, expv);
    endtask

    task automatic idle(input int n, input logic hs);
        for (int k = 0; k < n; k++) drive(24'hABCDEF, 8'h33, hs, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic frame(input logic [23:0] a, input logic [7:0] tm, input logic [1:0] md,
                         input int sat_exp);
        i_atmos = a; i_t_min = tm; i_mode = md;
        repeat (2) drive(24'hABCDEF, 8'h33, 1'b0, 1'b1, 1'b0, 24'h0);
        idle(10, 1'b0);
        check("sat_cnt", o_sat_cnt, sat_exp);
    endtask

    always @(negedge pixelclk) begin
        if (exp_q.size() > 0 && exp_q[0].stamp <= cyc_n) begin
            mon_e = exp_q.pop_front();
            check($sformatf("stamp@%0d", mon_e.stamp), cyc_n, mon_e.stamp);
            check("sync{hs,vs,de}", {o_hsync, o_vsync, o_de}, mon_e.sync);
            check("pixel", o_defogging, mon_e.pix);
        end
    end

    initial begin
        repeat (3) @(posedge pixelclk);
        #1;
        check("rst_pixel", o_defogging, 0);
        check("rst_sync", {o_hsync, o_vsync, o_de}, 0);
        check("rst_sat", o_sat_cnt, 0);
        @(negedge pixelclk);
        reset_n = 1'b1;
        idle(3, 1'b0);

        // Identity, haze lift, t_min floor, mid-frame changes ignored, clamp high
        frame(24'hC8C8C8, 8'd26, 2'b00, 0);
        pix(24'h646464, 8'hFF, 24'h646464);
        pix(24'h646464, 8'h80, 24'h010101);
        pix(24'hC9C7C8, 8'h0A, 24'hD2BEC8);
        idle(2, 1'b1);
        i_atmos = 24'h323232; i_mode = 2'b01;
        pix(24'h646464, 8'h80, 24'h010101);
        repeat (10) pix(24'hFAFAFA, 8'h40, 24'hFFFFFF);
        idle(3, 1'b1);

        // t = t_min = 0 -> divisor 1; clamp low on one channel
        frame(24'hC8C8C8, 8'd0, 2'b00, 30);
        pix(24'hC8C8C8, 8'h00, 24'hC8C8C8);
        repeat (3) pix(24'h00C8C8, 8'h80, 24'h00C8C8);
        idle(3, 1'b1);

        // Bypass: unchanged, no clamp counting
        frame(24'hC8C8C8, 8'd26, 2'b01, 3);
        pix(24'h123456, 8'h05, 24'h123456);
        pix(24'hFAFAFA, 8'h40, 24'hFAFAFA);
        idle(3, 1'b1);

        // Transmittance view
        frame(24'hC8C8C8, 8'd26, 2'b10, 0);
        pix(24'h123456, 8'h4D, 24'h4D4D4D);
        pix(24'hFFFFFF, 8'h00, 24'h000000);
        idle(3, 1'b1);

        // Mode 11 recovers; reset lands mid-frame with pixels in flight
        frame(24'hC8C8C8, 8'd26, 2'b11, 0);
        pix(24'hFAFAFA, 8'h40, 24'hFFFFFF);
        repeat (5) pix(24'h646464, 8'hFF, 24'h646464);
        #2;
        check("pre_rst_de", o_de, 1);
        reset_n = 1'b0;
        i_de = 1'b0;
        #1;
        check("async_rst_pixel", o_defogging, 0);
        check("async_rst_sync", {o_hsync, o_vsync, o_de}, 0);
        check("async_rst_sat", o_sat_cnt, 0);
        exp_q.delete();
        repeat (2) @(negedge pixelclk);
        reset_n = 1'b1;

        // Reset-latched A=255, t_min=26, mode 00
        idle(3, 1'b0);
        pix(24'hFFFFFF, 8'h64, 24'hFFFFFF);
        pix(24'h646464, 8'hFF, 24'h646464);
        idle(3, 1'b0);
        frame(24'hC8C8C8, 8'd26, 2'b00, 0);
        pix(24'h646464, 8'h80, 24'h010101);
        idle(2, 1'b0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge pixelclk);
        check("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
